eth_tx_frame_gen: RTL
=====================

# eth_tx_frame_gen

Frame source for the MAC's direct TX data path: on command, builds one Ethernet frame (destination MAC, source MAC, EtherType, patterned payload) and streams it as 32-bit words over the valid/ready interface with start/end/byte-select markers. It then waits for the MAC's per-frame TX status and reports completion. It sits in the application clock domain beside the MAC top and drives that block's `tx_*` direct-access inputs, which are used when MCU data access is compiled out. Used for bring-up, loopback and throughput tests.

## Interface
- `ERR_MASK`, 8'hFE: status bits that mark a frame as failed
- `STAT_TIMEOUT`, 4095: clock cycles to wait for TX status after the last word
- `clk_app_i` in 1: application clock; all logic is in this domain
- `rst_clk_app` in 1: reset, asynchronous, active-high
- `start_i` in 1: single-cycle frame request; sampled only in IDLE
- `dst_mac_i` in 48: destination MAC; [47:40] is transmitted first
- `src_mac_i` in 48: source MAC; [47:40] is transmitted first
- `eth_type_i` in 16: EtherType; [15:8] is transmitted first
- `pay_len_i` in 11: payload bytes; clamped to the range 46..1500
- `seed_i` in 8: payload pattern seed
- `tx_valid_o` out 1: word valid
- `tx_data_o` out 32: frame bytes, with the earliest byte in [7:0]
- `tx_start_o` out 1: first word of the frame
- `tx_end_o` out 1: last word of the frame
- `tx_bytesel_o` out 2: valid bytes in the last word; 00 = 4, 01 = 1 ([7:0]), 10 = 2, 11 = 3; 00 on non-last words
- `tx_ready_i` in 1: MAC accepts the word when valid && ready
- `tx_status_i` in 8: MAC per-frame TX status
- `tx_status_valid_i` in 1: one-cycle status strobe
- `busy_o` out 1: a frame is in progress
- `done_o` out 1: one-cycle completion pulse
- `err_o` out 1: valid with `done_o`; status error or timeout
- `timeout_o` out 1: valid with `done_o`; no status was received
- `last_status_o` out 8: last captured status; 0 on timeout
- `frame_cnt_o` out 16: frames completed, wraps
- `err_cnt_o` out 16: frames with `err_o` set, wraps

## Operation
- States: IDLE, STREAM, WAIT_STAT, DONE.
- IDLE to STREAM on `start_i`.
  - All inputs are latched at the same edge.
  - L = clamp(`pay_len_i`, 46, 1500).
  - N = 14 + L total bytes; W = ceil(N/4) words.
- STREAM: word index w counts 0..W-1 and advances only on valid && ready.
  - Word byte b carries frame byte 4w+b.
  - Bytes 0-5 are the destination MAC, 6-11 the source MAC, 12-13 the EtherType, then payload.
- Payload byte k defaults to (seed + k) mod 256.
- Bytes at positions ≥ N in the last word are driven 0.
- `tx_start_o` = valid && w==0. `tx_end_o` = valid && w==W-1. `tx_bytesel_o` on the last word = N mod 4, encoded as above.
- Accept of the last word goes to WAIT_STAT and clears the timeout counter.
- WAIT_STAT:
  - On `tx_status_valid_i`: capture `last_status_o`; err = |(status & `ERR_MASK`); go to DONE.
  - When the counter reaches `STAT_TIMEOUT`: timeout = 1, err = 1, `last_status_o` = 0; go to DONE.
- DONE (one cycle):
  - Pulse `done_o` with `err_o`/`timeout_o`.
  - Increment `frame_cnt_o`, and `err_cnt_o` if err.
  - Go to IDLE.
- A status strobe outside WAIT_STAT is ignored.
- `start_i` outside IDLE is ignored, not queued.

## Timing
- Reset (asynchronous, any time, including mid-frame): state IDLE; every output 0, including both counters and `last_status_o`.
- A frame truncated by reset is not completed; the MAC sees `tx_valid_o` drop without `tx_end_o`.
- `start_i` at edge t: `busy_o` and `tx_valid_o` are 1 from t+1, with word 0 presented.
- Back-to-back: with ready held high, one word per cycle and no valid bubbles; W cycles from first to last word.
- While valid && !ready, `tx_data_o`, `tx_start_o`, `tx_end_o` and `tx_bytesel_o` hold stable.
- `tx_valid_o` deasserts in the cycle after the last word is accepted.
- A status strobe at edge s gives `done_o` high in cycle s+1; `busy_o` falls with `done_o`.
- A new `start_i` is accepted in the cycle after `done_o`.
- A status strobe in the same cycle as the last-word accept is ignored; the MAC never issues status before accept.
- Timeout: `done_o` occurs `STAT_TIMEOUT`+1 cycles after the last accept.
- Counters wrap 16'hFFFF to 0.
- Outputs are registered; there is no combinational path from `tx_ready_i` to `tx_data_o`.

## Configuration
- `ETH_TX_GEN_LFSR_EN` defined: payload byte k is the LFSR state after k+1 steps.
  - The LFSR is an 8-bit Galois LFSR: shift right, XOR 8'hB8 when the output bit is 1.
  - It is loaded with `seed_i`; a seed of 0 is loaded as 8'h01.
  - It advances up to 4 steps per cycle.
- Undefined: incrementing pattern (seed + k); no LFSR logic is built.

## Test plan
- Minimum frame, pay_len=46, ready held 1:
  - Response: W=15, start on word 0, end on word 14, bytesel=00.
  - Word 0 = {dst[23:16],dst[31:24],dst[39:32],dst[47:40]}.
  - Status 8'h01 gives done, err=0, frame_cnt=1.
- pay_len=47, 48, 49:
  - Last bytesel 01/10/11 respectively; unused bytes are 0.
  - pay_len=10 is clamped to 46; pay_len=2000 is clamped to 1500 (W=379).
- Ready toggling 1010… across a 64-byte payload:
  - Outputs stay stable while stalled; every byte is correct with none dropped or duplicated.
  - Status 8'h02 gives err=1, err_cnt=1.
- No status, with STAT_TIMEOUT=15:
  - done arrives 16 cycles after the last accept, with timeout=1, err=1, last_status=0.
  - start_i pulsed during the frame is ignored.
- Reset asserted mid-STREAM (word 5):
  - All outputs go 0 immediately; the next start sends a full frame from word 0.
  - With the LFSR enabled and seed 0x00, payload byte 0 = 8'hB8.

Source files
------------

// File: rtl/eth_tx_frame_gen_if.sv
// eth_tx_frame_gen_if: 32-bit TX word stream toward the MAC direct-access path.
// The master drives words and frame markers; the slave answers with ready.
interface eth_tx_frame_gen_if;
    logic        tx_valid_o;
    logic [31:0] tx_data_o;
    logic        tx_start_o;
    logic        tx_end_o;
    logic [1:0]  tx_bytesel_o;
    logic        tx_ready_i;

    modport master (
        output tx_valid_o, tx_data_o, tx_start_o, tx_end_o, tx_bytesel_o,
        input  tx_ready_i
    );

    modport slave (
        input  tx_valid_o, tx_data_o, tx_start_o, tx_end_o, tx_bytesel_o,
        output tx_ready_i
    );
endinterface

// File: rtl/eth_tx_frame_gen.sv
// eth_tx_frame_gen: builds one Ethernet frame on command, streams it as 32-bit
// words, then waits for the MAC TX status. Option macro: ETH_TX_GEN_LFSR_EN.
module eth_tx_frame_gen #(
    parameter logic [7:0] ERR_MASK     = 8'hFE,
    parameter int         STAT_TIMEOUT = 4095
) (
    input  logic               clk_app_i,
    input  logic               rst_clk_app,
    input  logic               start_i,
    input  logic [47:0]        dst_mac_i,
    input  logic [47:0]        src_mac_i,
    input  logic [15:0]        eth_type_i,
    input  logic [10:0]        pay_len_i,
    input  logic [7:0]         seed_i,
    eth_tx_frame_gen_if.master tx,
    input  logic [7:0]         tx_status_i,
    input  logic               tx_status_valid_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               timeout_o,
    output logic [7:0]         last_status_o,
    output logic [15:0]        frame_cnt_o,
    output logic [15:0]        err_cnt_o
);

    localparam int TW = (STAT_TIMEOUT < 1) ? 1 : $clog2(STAT_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(STAT_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_STAT,
        DONE
    } state_t;

    state_t        state;

    logic [111:0]  hdr_q;
    logic [10:0]   n_q;
    logic [8:0]    w_q;
    logic [8:0]    wlast_q;
    logic [7:0]    pat_q;
    logic [TW-1:0] tcnt_q;

    logic          valid_q;
    logic [31:0]   data_q;
    logic          start_q;
    logic          end_q;
    logic [1:0]    bsel_q;

    logic [10:0]   len_in;
    logic [10:0]   n_in;
    logic [8:0]    wlast_in;
    logic [7:0]    seed_ld;

    logic [8:0]    g_w;
    logic [8:0]    g_wlast;
    logic [10:0]   g_n;
    logic [111:0]  g_hdr;
    logic [7:0]    g_pat;
    logic [7:0]    nxt_pat;
    logic [31:0]   nxt_data;
    logic          nxt_last;
    logic          stat_err;

`ifdef ETH_TX_GEN_LFSR_EN
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // State after stepping once per payload byte that lands in word w.
    function automatic logic [7:0] lfsr_adv(
        input logic [8:0]  w,
        input logic [10:0] n,
        input logic [7:0]  s
    );
        logic [7:0]  lf;
        logic [10:0] pos;
        lf = s;
        for (int b = 0; b < 4; b++) begin
            pos = {w, 2'b00} + 11'(b);
            if (pos >= 11'd14 && pos < n) begin
                lf = lfsr_step(lf);
            end
        end
        return lf;
    endfunction
`endif

    // Word w of the frame: header bytes, then pattern bytes, zero past N.
    // pat is the seed (incrementing) or the LFSR state before this word.
    function automatic logic [31:0] gen_word(
        input logic [8:0]   w,
        input logic [10:0]  n,
        input logic [111:0] hdr,
        input logic [7:0]   pat
    );
        logic [31:0] d;
        logic [10:0] pos;
        logic [7:0]  v;
`ifdef ETH_TX_GEN_LFSR_EN
        logic [7:0]  lf;
        lf = pat;
`endif
        d = '0;
        for (int b = 0; b < 4; b++) begin
            pos = {w, 2'b00} + 11'(b);
            v   = 8'h00;
            if (pos >= n) begin
                v = 8'h00;
            end else if (pos < 11'd14) begin
                v = 8'(hdr >> (104 - 8 * int'(pos)));
            end else begin
`ifdef ETH_TX_GEN_LFSR_EN
                lf = lfsr_step(lf);
                v  = lf;
`else
                v  = pat + pos[7:0] - 8'd14;
`endif
            end
            d[8*b +: 8] = v;
        end
        return d;
    endfunction

    // Clamp the payload length and size the frame from the live inputs.
    always_comb begin
        len_in = pay_len_i;
        if (pay_len_i < 11'd46) begin
            len_in = 11'd46;
        end else if (pay_len_i > 11'd1500) begin
            len_in = 11'd1500;
        end
        n_in     = len_in + 11'd14;
        wlast_in = 9'(((n_in + 11'd3) >> 2) - 11'd1);
`ifdef ETH_TX_GEN_LFSR_EN
        seed_ld  = (seed_i == 8'h00) ? 8'h01 : seed_i;
`else
        seed_ld  = seed_i;
`endif
    end

    // Next word to register: word 0 from live inputs in IDLE, else w+1.
    always_comb begin
        g_w     = w_q + 9'd1;
        g_wlast = wlast_q;
        g_n     = n_q;
        g_hdr   = hdr_q;
        g_pat   = pat_q;
        if (state == IDLE) begin
            g_w     = '0;
            g_wlast = wlast_in;
            g_n     = n_in;
            g_hdr   = {dst_mac_i, src_mac_i, eth_type_i};
            g_pat   = seed_ld;
        end
        nxt_data = gen_word(g_w, g_n, g_hdr, g_pat);
        nxt_last = (g_w == g_wlast);
`ifdef ETH_TX_GEN_LFSR_EN
        nxt_pat  = lfsr_adv(g_w, g_n, g_pat);
`else
        nxt_pat  = g_pat;
`endif
    end

    assign stat_err = |(tx_status_i & ERR_MASK);

    // Frame FSM with all outputs registered.
    always_ff @(posedge clk_app_i or posedge rst_clk_app) begin
        if (rst_clk_app) begin
            state         <= IDLE;
            hdr_q         <= '0;
            n_q           <= '0;
            w_q           <= '0;
            wlast_q       <= '0;
            pat_q         <= '0;
            tcnt_q        <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            start_q       <= 1'b0;
            end_q         <= 1'b0;
            bsel_q        <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            timeout_o     <= 1'b0;
            last_status_o <= '0;
            frame_cnt_o   <= '0;
            err_cnt_o     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        hdr_q   <= g_hdr;
                        n_q     <= n_in;
                        wlast_q <= wlast_in;
                        w_q     <= '0;
                        pat_q   <= nxt_pat;
                        valid_q <= 1'b1;
                        data_q  <= nxt_data;
                        start_q <= 1'b1;
                        end_q   <= nxt_last;
                        bsel_q  <= nxt_last ? n_in[1:0] : 2'b00;
                        busy_o  <= 1'b1;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (tx.tx_ready_i) begin
                        if (w_q == wlast_q) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            start_q <= 1'b0;
                            end_q   <= 1'b0;
                            bsel_q  <= '0;
                            tcnt_q  <= '0;
                            state   <= WAIT_STAT;
                        end else begin
                            w_q     <= g_w;
                            pat_q   <= nxt_pat;
                            data_q  <= nxt_data;
                            start_q <= 1'b0;
                            end_q   <= nxt_last;
                            bsel_q  <= nxt_last ? n_q[1:0] : 2'b00;
                        end
                    end
                end
                WAIT_STAT: begin
                    if (tx_status_valid_i) begin
                        last_status_o <= tx_status_i;
                        err_o         <= stat_err;
                        timeout_o     <= 1'b0;
                        done_o        <= 1'b1;
                        busy_o        <= 1'b0;
                        frame_cnt_o   <= frame_cnt_o + 16'd1;
                        if (stat_err) begin
                            err_cnt_o <= err_cnt_o + 16'd1;
                        end
                        state         <= DONE;
                    end else if (tcnt_q == TO_LAST) begin
                        last_status_o <= '0;
                        err_o         <= 1'b1;
                        timeout_o     <= 1'b1;
                        done_o        <= 1'b1;
                        busy_o        <= 1'b0;
                        frame_cnt_o   <= frame_cnt_o + 16'd1;
                        err_cnt_o     <= err_cnt_o + 16'd1;
                        state         <= DONE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                DONE: begin
                    done_o    <= 1'b0;
                    err_o     <= 1'b0;
                    timeout_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_valid_o   = valid_q;
    assign tx.tx_data_o    = data_q;
    assign tx.tx_start_o   = start_q;
    assign tx.tx_end_o     = end_q;
    assign tx.tx_bytesel_o = bsel_q;

endmodule
